// File: rtl/chess_pkg.sv
// Shared constants, direction codes, offset tables and FSM encoding for the
// chess move generator blocks.
package chess_pkg;

    localparam int PIECE_W = 4;
    localparam int EMPTY   = 0;

    localparam logic [2:0] UPLEFTLEFT     = 3'd0;
    localparam logic [2:0] UPUPLEFT       = 3'd1;
    localparam logic [2:0] UPUPRIGHT      = 3'd2;
    localparam logic [2:0] UPRIGHTRIGHT   = 3'd3;
    localparam logic [2:0] DOWNRIGHTRIGHT = 3'd4;
    localparam logic [2:0] DOWNDOWNRIGHT  = 3'd5;
    localparam logic [2:0] DOWNDOWNLEFT   = 3'd6;
    localparam logic [2:0] LEFTLEFTDOWN   = 3'd7;

    localparam logic [2:0] N  = 3'd0;
    localparam logic [2:0] NE = 3'd1;
    localparam logic [2:0] E  = 3'd2;
    localparam logic [2:0] SE = 3'd3;
    localparam logic [2:0] S  = 3'd4;
    localparam logic [2:0] SW = 3'd5;
    localparam logic [2:0] W  = 3'd6;
    localparam logic [2:0] NW = 3'd7;

    typedef enum logic [1:0] {IDLE, STEP, DONE} scan_state_t;

    function automatic logic signed [2:0] knight_dcol(input logic [2:0] dir);
        case (dir)
            UPLEFTLEFT, LEFTLEFTDOWN:       return -3'sd2;
            UPUPLEFT, DOWNDOWNLEFT:         return -3'sd1;
            UPUPRIGHT, DOWNDOWNRIGHT:       return 3'sd1;
            default:                        return 3'sd2;
        endcase
    endfunction

    function automatic logic signed [2:0] knight_drow(input logic [2:0] dir);
        case (dir)
            UPUPLEFT, UPUPRIGHT:            return -3'sd2;
            UPLEFTLEFT, UPRIGHTRIGHT:       return -3'sd1;
            DOWNRIGHTRIGHT, LEFTLEFTDOWN:   return 3'sd1;
            default:                        return 3'sd2;
        endcase
    endfunction

    function automatic logic signed [2:0] slide_dcol(input logic [2:0] dir);
        case (dir)
            NE, E, SE:                      return 3'sd1;
            SW, W, NW:                      return -3'sd1;
            default:                        return 3'sd0;
        endcase
    endfunction

    function automatic logic signed [2:0] slide_drow(input logic [2:0] dir);
        case (dir)
            NW, N, NE:                      return -3'sd1;
            SE, S, SW:                      return 3'sd1;
            default:                        return 3'sd0;
        endcase
    endfunction

endpackage

// File: rtl/board_cell_mux.sv
// Selects the piece code of one square from a packed board.
module board_cell_mux #(
    parameter int BOARD_DIM = 8,
    parameter int PIECE_W   = 4,
    localparam int POS_W    = 2 * $clog2(BOARD_DIM)
) (
    input  logic [POS_W-1:0]                       square,
    input  logic [BOARD_DIM*BOARD_DIM*PIECE_W-1:0] board,
    output logic [PIECE_W-1:0]                     piece
);

    assign piece = board[square*PIECE_W +: PIECE_W];

endmodule

// File: rtl/move_ray_scanner.sv
// Walks a captured board from a start square along a knight jump or a
// sliding ray, one square per clock, and reports the nearest occupied square.
module move_ray_scanner #(
    parameter int BOARD_DIM = 8,
    parameter int PIECE_W   = 4,
    localparam int LOG_DIM  = $clog2(BOARD_DIM),
    localparam int POS_W    = 2 * LOG_DIM,
    localparam int STEP_W   = LOG_DIM + 1,
    localparam int CW       = LOG_DIM + 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   mode,
    input  logic [2:0]                             direction,
    input  logic [POS_W-1:0]                       currentPosition,
    input  logic [BOARD_DIM*BOARD_DIM*PIECE_W-1:0] bigBoard,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   found,
    output logic [POS_W-1:0]                       nearestPosition,
    output logic [PIECE_W-1:0]                     nearestPiece,
    output logic [STEP_W-1:0]                      steps
);
    import chess_pkg::*;

    scan_state_t                            state;
    logic [LOG_DIM-1:0]                     cur_col;
    logic [LOG_DIM-1:0]                     cur_row;
    logic [2:0]                             dir_q;
    logic                                   mode_q;
    logic [BOARD_DIM*BOARD_DIM*PIECE_W-1:0] board_q;

    logic signed [2:0]    dcol;
    logic signed [2:0]    drow;
    logic signed [CW-1:0] next_col;
    logic signed [CW-1:0] next_row;
    logic                 off_board;
    logic [POS_W-1:0]     next_idx;
    logic [PIECE_W-1:0]   next_piece;

    // Col/row are one bit wider than needed, so every off-board target
    // (below 0 or at/above BOARD_DIM) lands with its sign bit set.
    always_comb begin
        dcol      = mode_q ? slide_dcol(dir_q) : knight_dcol(dir_q);
        drow      = mode_q ? slide_drow(dir_q) : knight_drow(dir_q);
        next_col  = $signed({1'b0, cur_col}) + CW'(dcol);
        next_row  = $signed({1'b0, cur_row}) + CW'(drow);
        off_board = next_col[CW-1] | next_row[CW-1];
        next_idx  = {next_row[LOG_DIM-1:0], next_col[LOG_DIM-1:0]};
    end

    board_cell_mux #(
        .BOARD_DIM(BOARD_DIM),
        .PIECE_W  (PIECE_W)
    ) u_cell_mux (
        .square(next_idx),
        .board (board_q),
        .piece (next_piece)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cur_col         <= '0;
            cur_row         <= '0;
            dir_q           <= '0;
            mode_q          <= 1'b0;
            board_q         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            found           <= 1'b0;
            nearestPosition <= '0;
            nearestPiece    <= '0;
            steps           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_col <= currentPosition[LOG_DIM-1:0];
                        cur_row <= currentPosition[POS_W-1:LOG_DIM];
                        dir_q   <= direction;
                        mode_q  <= mode;
                        board_q <= bigBoard;
                        steps   <= '0;
                        busy    <= 1'b1;
                        state   <= STEP;
                    end
                end
                STEP: begin
                    if (off_board) begin
                        found           <= 1'b0;
                        nearestPosition <= {cur_row, cur_col};
                        nearestPiece    <= '0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        state           <= DONE;
                    end else if (next_piece != PIECE_W'(EMPTY)) begin
                        found           <= 1'b1;
                        nearestPosition <= next_idx;
                        nearestPiece    <= next_piece;
                        steps           <= steps + STEP_W'(1);
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        state           <= DONE;
                    end else if (!mode_q) begin
                        found           <= 1'b0;
                        nearestPosition <= next_idx;
                        nearestPiece    <= '0;
                        steps           <= STEP_W'(1);
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        state           <= DONE;
                    end else begin
                        cur_col <= next_col[LOG_DIM-1:0];
                        cur_row <= next_row[LOG_DIM-1:0];
                        steps   <= steps + STEP_W'(1);
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_ray_scanner.sv
// Directed bench for move_ray_scanner: a ray-walking reference model checked
// every cycle, plus literal expectations for each directed scan.
module tb_move_ray_scanner;

    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [2:0]   direction = '0;
    logic [5:0]   currentPosition = '0;
    logic [255:0] bigBoard;
    logic [3:0]   bb [64];

    logic         busy;
    logic         done;
    logic         found;
    logic [5:0]   nearestPosition;
    logic [3:0]   nearestPiece;
    logic [3:0]   steps;

    int n_checks = 0;
    int n_fail   = 0;

    int kdc [8] = '{-2, -1, 1, 2, 2, 1, -1, -2};
    int kdr [8] = '{-1, -2, -2, -1, 1, 2, 2, 1};
    int sdc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int sdr [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    bit m_busy = 0, m_done = 0, m_found = 0, m_cool = 0;
    int m_pos = 0, m_piece = 0, m_steps = 0, m_left = 0;
    bit p_found;
    int p_pos, p_piece, p_steps;

    move_ray_scanner #(.BOARD_DIM(8), .PIECE_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mode           (mode),
        .direction      (direction),
        .currentPosition(currentPosition),
        .bigBoard       (bigBoard),
        .busy           (busy),
        .done           (done),
        .found          (found),
        .nearestPosition(nearestPosition),
        .nearestPiece   (nearestPiece),
        .steps          (steps)
    );

    always #5 clk = ~clk;

    always_comb begin
        bigBoard = '0;
        for (int i = 0; i < 64; i++) bigBoard[i*4 +: 4] = bb[i];
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Walk the ray square by square on the current board.
    function automatic void predict(input int pos, input int dir, input bit md,
                                    output bit f, output int p, output int pc,
                                    output int st, output int n);
        int c, r, dc, dr, nc, nr;
        c = pos % D;
        r = pos / D;
        dc = md ? sdc[dir] : kdc[dir];
        dr = md ? sdr[dir] : kdr[dir];
        f = 0; p = pos; pc = 0; st = 0; n = 0;
        for (int i = 0; i < 2 * D; i++) begin
            n++;
            nc = c + dc;
            nr = r + dr;
            if (nc < 0 || nc >= D || nr < 0 || nr >= D) begin
                p = r * D + c;
                return;
            end
            st++;
            p = nr * D + nc;
            if (bb[p] != 0) begin
                f = 1;
                pc = int'(bb[p]);
                return;
            end
            if (!md) return;
            c = nc;
            r = nr;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_found = 0; m_cool = 0;
            m_pos = 0; m_piece = 0; m_steps = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_cool = 1;
                    m_found = p_found;
                    m_pos = p_pos;
                    m_piece = p_piece;
                    m_steps = p_steps;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else if (start) begin
                predict(int'(currentPosition), int'(direction), mode,
                        p_found, p_pos, p_piece, p_steps, m_left);
                m_busy = 1;
                m_steps = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("found", int'(found), int'(m_found));
        chk("nearestPosition", int'(nearestPosition), m_pos);
        chk("nearestPiece", int'(nearestPiece), m_piece);
        if (!m_busy) chk("steps", int'(steps), m_steps);
    end

    task automatic run_scan(input int pos, input int dir, input bit md,
                            input int exp_f, input int exp_p, input int exp_pc,
                            input int exp_st, input int exp_n, input bit extra);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        mode = md;
        direction = 3'(dir);
        currentPosition = 6'(pos);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (extra && cyc == 1) begin
                start = 1'b1;
                currentPosition = 6'd27;
                bb[35] = 4'h5;
            end
            if (extra && cyc == 2) start = 1'b0;
        end
        chk("latency", cyc, exp_n);
        chk("res_found", int'(found), exp_f);
        chk("res_pos", int'(nearestPosition), exp_p);
        chk("res_piece", int'(nearestPiece), exp_pc);
        chk("res_steps", int'(steps), exp_st);
        chk("res_busy", int'(busy), 0);
        chk("model_pos", m_pos, exp_p);
        chk("model_steps", m_steps, exp_st);
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_done;
        for (int i = 0; i < 64; i++) bb[i] = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_steps", int'(steps), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_scan(27, 2, 1, 0, 31, 0, 4, 5, 0);
        bb[30] = 4'h9;
        run_scan(27, 2, 1, 1, 30, 9, 3, 3, 0);
        bb[30] = 4'h0;
        run_scan(0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_scan(7, 2, 1, 0, 7, 0, 0, 1, 0);
        bb[37] = 4'h3;
        run_scan(27, 4, 0, 1, 37, 3, 1, 1, 0);
        bb[37] = 4'h0;
        run_scan(27, 4, 0, 0, 37, 0, 1, 1, 0);
        bb[9] = 4'hC;
        run_scan(27, 7, 1, 1, 9, 12, 2, 2, 0);
        bb[9] = 4'h0;
        run_scan(27, 1, 0, 0, 10, 0, 1, 1, 0);
        run_scan(7, 5, 1, 0, 56, 0, 7, 8, 0);
        run_scan(3, 4, 1, 0, 59, 0, 7, 8, 1);
        bb[35] = 4'h0;

        // Asynchronous reset in the middle of a long ray.
        @(negedge clk);
        start = 1'b1;
        mode = 1'b1;
        direction = 3'd4;
        currentPosition = 6'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_found", int'(found), 0);
        chk("arst_pos", int'(nearestPosition), 0);
        chk("arst_piece", int'(nearestPiece), 0);
        chk("arst_steps", int'(steps), 0);
        saw_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        chk("no_done_after_reset", int'(saw_done), 0);
        run_scan(3, 4, 1, 0, 59, 0, 7, 8, 0);

        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
